// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if: requester buses, monitor lock and device-side signals for io_bus_arbiter
interface io_bus_arbiter_if #(parameter int NDEV = 4);
  logic              req0, we0, ack0, err0;
  logic [31:0]       addr0, wd0, rd0;
  logic              req1, we1, ack1, err1, lock1;
  logic [31:0]       addr1, wd1, rd1;
  logic [NDEV-1:0]   io_sel, io_we;
  logic [31:0]       io_wd;
  logic [NDEV*32-1:0] io_rd;
  modport slave (
    input  req0, we0, addr0, wd0, req1, we1, addr1, wd1, lock1, io_rd,
    output rd0, ack0, err0, rd1, ack1, err1, io_sel, io_we, io_wd
  );
  modport master (
    output req0, we0, addr0, wd0, req1, we1, addr1, wd1, lock1, io_rd,
    input  rd0, ack0, err0, rd1, ack1, err1, io_sel, io_we, io_wd
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: core/monitor round-robin arbiter with one-hot I/O decode and 3-cycle transactions
module io_bus_arbiter #(
  parameter int          NDEV = 4,
  parameter logic [31:0] BASE = 32'hFFFF_0000,
  parameter int          IDXW = 2
) (
  input logic             clk,
  input logic             reset_n,
  io_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t          r_state;
  logic            r_last, r_owner, r_we;
  logic [31:2]     r_addr;
  logic [31:0]     r_wd;
  logic            w_e0, w_e1, w_own, w_hit;
  logic [IDXW-1:0] w_idx;
  logic [NDEV-1:0] w_sel;
  logic [31:0]     w_rdata;
  assign w_e0    = bus.req0 & ~bus.lock1;
  assign w_e1    = bus.req1;
  // monitor wins when alone, or on contention when the core went last
  assign w_own   = w_e1 & (~w_e0 | ~r_last);
  assign w_idx   = r_addr[IDXW+1:2];
  assign w_hit   = r_addr[31:IDXW+2] == BASE[31:IDXW+2];
  assign w_rdata = w_hit ? bus.io_rd[{w_idx, 5'd0} +: 32] : '0;
  assign w_sel   = (r_state == ACCESS && w_hit) ? NDEV'(1) << w_idx : '0;
  assign bus.io_sel = w_sel;
  assign bus.io_we  = r_we ? w_sel : '0;
  assign bus.io_wd  = r_wd;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wd     <= '0;
      bus.rd0  <= '0;
      bus.rd1  <= '0;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.err0 <= 1'b0;
      bus.err1 <= 1'b0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (r_state)
        IDLE: if (w_e0 | w_e1) begin
          r_owner <= w_own;
          r_last  <= w_own;
          r_we    <= w_own ? bus.we1 : bus.we0;
          r_addr  <= w_own ? bus.addr1[31:2] : bus.addr0[31:2];
          r_wd    <= w_own ? bus.wd1 : bus.wd0;
          r_state <= ACCESS;
        end
        ACCESS: begin
          r_state <= ACK;
          if (r_owner) begin
            bus.ack1 <= 1'b1;
            bus.rd1  <= w_rdata;
            bus.err1 <= ~w_hit;
          end else begin
            bus.ack0 <= 1'b1;
            bus.rd0  <= w_rdata;
            bus.err0 <= ~w_hit;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
